// File: rtl/apb_master_bridge_if.sv
// Request-side and APB-side signal bundle for apb_master_bridge.
// The bridge uses the master view; the environment (requester plus slaves) uses the slave view.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  // request port
  logic              transfer;
  logic              READ_WRITE;
  logic [ADDR_W-1:0] apb_write_paddr;
  logic [ADDR_W-1:0] apb_read_paddr;
  logic [DATA_W-1:0] apb_write_data;

  // APB bus toward the slaves
  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-2:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR_IN;

  // completion status
  logic [DATA_W-1:0] apb_read_data_out;
  logic              PSLVERR;
  logic              xfer_done;

  modport master (
    input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
    input  PREADY, PRDATA, PSLVERR_IN,
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output apb_read_data_out, PSLVERR, xfer_done
  );

  modport slave (
    output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
    output PREADY, PRDATA, PSLVERR_IN,
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  apb_read_data_out, PSLVERR, xfer_done
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns a simple request port into SETUP/ACCESS phases toward two slaves,
// with a PREADY wait-state timeout that forces an error completion when a slave hangs.
module apb_master_bridge #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                PCLK,
  input logic                PRESETn,
  apb_master_bridge_if.master bus
);

  localparam int PADDR_W = ADDR_W - 1;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                psel1_q, psel1_d;
  logic                psel2_q, psel2_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [PADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                pslverr_q, pslverr_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                timeout;
  logic                load;
  logic [ADDR_W-1:0]   req_addr;

  // Counter sits at TIMEOUT_CYCLES-1 in the last ACCESS cycle a slave is allowed.
  assign timeout = (state_q == ACCESS) && !bus.PREADY && (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned
  // and infer a latch; blocking assignments are correct in combinational logic.
  always_comb begin
    state_d   = state_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    pslverr_d = pslverr_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    load      = 1'b0;
    req_addr  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.transfer) load = 1'b1;
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (bus.PREADY || timeout) begin
          done_d    = 1'b1;
          pslverr_d = (bus.PSLVERR_IN & bus.PREADY) | timeout;
          if (!pwrite_q && bus.PREADY) rdata_d = bus.PRDATA;
          penable_d = 1'b0;
          if (bus.transfer) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            psel1_d = 1'b0;
            psel2_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // New request accepted from IDLE or on a completion edge (back-to-back).
    if (load) begin
      req_addr  = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;
      state_d   = SETUP;
      penable_d = 1'b0;
      pwrite_d  = ~bus.READ_WRITE;
      if (!bus.READ_WRITE) pwdata_d = bus.apb_write_data;
      paddr_d   = req_addr[PADDR_W-1:0];
      psel1_d   = ~req_addr[ADDR_W-1];
      psel2_d   =  req_addr[ADDR_W-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      pslverr_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      pslverr_q <= pslverr_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PSEL1             = psel1_q;
  assign bus.PSEL2             = psel2_q;
  assign bus.PENABLE           = penable_q;
  assign bus.PWRITE            = pwrite_q;
  assign bus.PADDR             = paddr_q;
  assign bus.PWDATA            = pwdata_q;
  assign bus.apb_read_data_out = rdata_q;
  assign bus.PSLVERR           = pslverr_q;
  assign bus.xfer_done         = done_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, hand-written multi-cycle
// sequences (back-to-back, reset mid-ACCESS) and random transfers against a transaction model.
module tb_apb_master_bridge;

  localparam int ADDR_W         = 9;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic PCLK = 1'b0;
  logic PRESETn;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] all_outputs();
    return {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
            bus.apb_read_data_out, bus.PSLVERR, bus.xfer_done};
  endfunction

  typedef struct {
    string      name;
    bit         rd;
    logic [8:0] addr;
    logic [7:0] wdata;
    int         waits;      // PREADY=0 ACCESS cycles before the slave answers
    bit         serr;
    logic [7:0] prdata;
    bit         exp_psel1;
    bit         exp_psel2;
    logic [7:0] exp_paddr;
    int         exp_access;
    bit         exp_slverr;
    logic [7:0] exp_rdata;
  } vec_t;

  // One isolated transfer starting and ending in IDLE.
  task automatic run_xfer(input vec_t v);
    int n_access;
    int bad;
    @(negedge PCLK);
    bus.transfer       = 1'b1;
    bus.READ_WRITE     = v.rd;
    bus.apb_read_paddr  = v.rd ? v.addr : ~v.addr;
    bus.apb_write_paddr = v.rd ? ~v.addr : v.addr;
    bus.apb_write_data = v.wdata;
    bus.PREADY         = 1'b0;
    @(negedge PCLK);
    // SETUP: request accepted, inputs now ignored
    bus.transfer        = 1'b0;
    bus.apb_write_paddr = 9'($urandom);
    bus.apb_read_paddr  = 9'($urandom);
    bus.apb_write_data  = 8'($urandom);
    check({v.name, "_setup_psel"}, {bus.PSEL1, bus.PSEL2, bus.PENABLE},
          {v.exp_psel1, v.exp_psel2, 1'b0});
    check({v.name, "_setup_paddr"}, bus.PADDR, v.exp_paddr);
    check({v.name, "_setup_pwrite"}, bus.PWRITE, !v.rd);
    if (!v.rd) check({v.name, "_setup_pwdata"}, bus.PWDATA, v.wdata);
    @(negedge PCLK);
    n_access = 0;
    bad = 0;
    while (bus.xfer_done !== 1'b1 && n_access <= TIMEOUT_CYCLES + 1) begin
      n_access++;
      if (bus.PENABLE !== 1'b1 || bus.PSEL1 !== v.exp_psel1 || bus.PSEL2 !== v.exp_psel2 ||
          bus.PADDR !== v.exp_paddr || bus.PWRITE !== !v.rd ||
          (!v.rd && bus.PWDATA !== v.wdata))
        bad++;
      if (n_access > v.waits) begin
        bus.PREADY     = 1'b1;
        bus.PRDATA     = v.prdata;
        bus.PSLVERR_IN = v.serr;
      end else begin
        bus.PREADY     = 1'b0;
        bus.PRDATA     = 8'($urandom);
        bus.PSLVERR_IN = 1'($urandom);
      end
      @(negedge PCLK);
    end
    bus.PREADY     = 1'b0;
    bus.PSLVERR_IN = 1'b0;
    check({v.name, "_access_stable"}, bad, 0);
    check({v.name, "_done"}, bus.xfer_done, 1'b1);
    check({v.name, "_access_cycles"}, n_access, v.exp_access);
    check({v.name, "_pslverr"}, bus.PSLVERR, v.exp_slverr);
    check({v.name, "_rdata"}, bus.apb_read_data_out, v.exp_rdata);
    check({v.name, "_idle_bus"}, {bus.PSEL1, bus.PSEL2, bus.PENABLE}, 3'b000);
    model_rdata = v.exp_rdata;
    @(negedge PCLK);
    check({v.name, "_done_pulse"}, bus.xfer_done, 1'b0);
  endtask

  // Transaction-level expectation from the bridge's rules.
  function automatic vec_t model_vec(input string name, input bit rd, input logic [8:0] addr,
                                     input logic [7:0] wdata, input int waits, input bit serr,
                                     input logic [7:0] prdata);
    vec_t v;
    bit   to;
    to           = (waits >= TIMEOUT_CYCLES);
    v.name       = name;
    v.rd         = rd;
    v.addr       = addr;
    v.wdata      = wdata;
    v.waits      = waits;
    v.serr       = serr;
    v.prdata     = prdata;
    v.exp_psel1  = (addr < 9'd256);
    v.exp_psel2  = (addr >= 9'd256);
    v.exp_paddr  = 8'(addr % 256);
    v.exp_access = to ? TIMEOUT_CYCLES : waits + 1;
    v.exp_slverr = to || serr;
    v.exp_rdata  = (rd && !to) ? prdata : model_rdata;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"wr_0a5",    1'b0, 9'h0A5, 8'h3C, 0,  1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1,  1'b0, 8'h00};
    vecs[1] = '{"rd_1f0",    1'b1, 9'h1F0, 8'h00, 3,  1'b0, 8'h5A, 1'b0, 1'b1, 8'hF0, 4,  1'b0, 8'h5A};
    vecs[2] = '{"rd_tmo",    1'b1, 9'h020, 8'h00, 99, 1'b0, 8'hEE, 1'b1, 1'b0, 8'h20, 16, 1'b1, 8'h5A};
    vecs[3] = '{"wr_serr",   1'b0, 9'h001, 8'h44, 0,  1'b1, 8'h00, 1'b1, 1'b0, 8'h01, 1,  1'b1, 8'h5A};
    vecs[4] = '{"rd_clean",  1'b1, 9'h155, 8'h00, 1,  1'b0, 8'hC3, 1'b0, 1'b1, 8'h55, 2,  1'b0, 8'hC3};
    vecs[5] = '{"rd_serr",   1'b1, 9'h0FF, 8'h00, 0,  1'b1, 8'h77, 1'b1, 1'b0, 8'hFF, 1,  1'b1, 8'h77};
    vecs[6] = '{"rd_wait15", 1'b1, 9'h1C0, 8'h00, 15, 1'b0, 8'h12, 1'b0, 1'b1, 8'hC0, 16, 1'b0, 8'h12};
    vecs[7] = '{"rd_wait16", 1'b1, 9'h0C0, 8'h00, 16, 1'b0, 8'h34, 1'b1, 1'b0, 8'hC0, 16, 1'b1, 8'h12};

    PRESETn             = 1'b0;
    bus.transfer        = 1'b0;
    bus.READ_WRITE      = 1'b0;
    bus.apb_write_paddr = '0;
    bus.apb_read_paddr  = '0;
    bus.apb_write_data  = '0;
    bus.PREADY          = 1'b0;
    bus.PRDATA          = '0;
    bus.PSLVERR_IN      = 1'b0;
    model_rdata         = 8'h00;
    #1;
    check("reset_outputs", all_outputs(), 30'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("idle_after_reset", all_outputs(), 30'h0);

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Back-to-back: write 0x010/0x11 then read 0x110 with transfer held high.
    @(negedge PCLK);
    bus.transfer        = 1'b1;
    bus.READ_WRITE      = 1'b0;
    bus.apb_write_paddr = 9'h010;
    bus.apb_write_data  = 8'h11;
    @(negedge PCLK);
    check("b2b_setup1", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PADDR}, {3'b100, 8'h10});
    bus.READ_WRITE     = 1'b1;
    bus.apb_read_paddr = 9'h110;
    @(negedge PCLK);
    check("b2b_access1", {bus.PSEL1, bus.PENABLE, bus.PWRITE, bus.PWDATA}, {3'b111, 8'h11});
    bus.PREADY = 1'b1;
    @(negedge PCLK);
    check("b2b_done1", bus.xfer_done, 1'b1);
    check("b2b_setup2", {bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.PADDR},
          {4'b0100, 8'h10});
    check("b2b_pslverr1", bus.PSLVERR, 1'b0);
    bus.transfer = 1'b0;
    bus.PRDATA   = 8'h99;
    @(negedge PCLK);
    check("b2b_access2", {bus.PSEL2, bus.PENABLE, bus.xfer_done}, 3'b110);
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    check("b2b_done2", {bus.xfer_done, bus.PSEL2, bus.apb_read_data_out}, {2'b10, 8'h99});
    model_rdata = 8'h99;
    @(negedge PCLK);

    // Reset while a slave holds PREADY low.
    bus.transfer       = 1'b1;
    bus.READ_WRITE     = 1'b1;
    bus.apb_read_paddr = 9'h1AB;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_mid_inflight", {bus.PSEL2, bus.PENABLE}, 2'b11);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_outputs", all_outputs(), 30'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    check("rst_mid_no_done", bus.xfer_done, 1'b0);
    model_rdata = 8'h00;
    run_xfer(model_vec("post_rst_wr", 1'b0, 9'h133, 8'hA7, 0, 1'b0, 8'h00));

    // Random transfers against the transaction model.
    for (int i = 0; i < 30; i++) begin
      bit         rd;
      logic [8:0] addr;
      int         waits;
      rd    = 1'($urandom);
      addr  = 9'($urandom_range(0, 511));
      waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      run_xfer(model_vec($sformatf("rnd%0d", i), rd, addr, 8'($urandom), waits,
                         ($urandom_range(0, 3) == 0), 8'($urandom)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
